fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage, directly downstream of the pc register block.
//  - Turns the current PC into instruction-memory requests.
//  - Tracks in-order outstanding requests and buffers returned words in an in-order queue.
//  - Presents {pc, instr} to decode over a valid/ready handshake.
//  - Drives the pc block's stall input; squashes all in-flight and queued work on redirect.
// PARAMETERS
//  DEPTH         4             queue entries (power of 2, >=2); bounds outstanding + buffered
//  RESET_VECTOR  32'h00000000  if_pc_o value while the queue is empty after reset (must match pc block)
// PORTS
//  clk               in   1   clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  pc_i              in   32  current PC from pc block
//  pc_stall_o        out  1   to pc block stall; 1 = hold PC this cycle
//  redirect_valid_i  in   1   branch/exception redirect (same pulse the pc block sees)
//  imem_req_valid_o  out  1   fetch request valid
//  imem_req_addr_o   out  32  fetch address (= pc_i)
//  imem_req_ready_i  in   1   memory accepts request
//  imem_rsp_valid_i  in   1   response valid; responses return in request order, >=1 cycle later
//  imem_rsp_data_i   in   32  instruction word
//  if_valid_o        out  1   fetched instruction valid to decode
//  if_pc_o           out  32  PC of head instruction
//  if_instr_o        out  32  head instruction word
//  if_ready_i        in   1   decode accepts head
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - Queue empty, occupancy=0, drop_cnt=0.
//  - imem_req_valid_o=0, if_valid_o=0, if_pc_o=RESET_VECTOR, if_instr_o=0, pc_stall_o=1.
//  - Reset may assert mid-operation; all state clears, pending responses are NOT dropped.
//    Memory is assumed reset together with this block.
//  Queue: DEPTH entries {pc, instr, filled}; pointers alloc, fill, head.
//  - Occupancy counts allocated entries (filled or not); range 0..DEPTH.
//  Request: imem_req_valid_o = !redirect_valid_i && (occupancy < DEPTH || head pops this cycle).
//  - Accept = valid && ready: allocate entry at alloc with pc=pc_i, filled=0.
//  - pc_stall_o = !accept, so the PC advances exactly once per accepted request.
//  Response: when imem_rsp_valid_i && drop_cnt==0, write data into entry at fill and set filled.
//  - When drop_cnt>0, discard the response and decrement drop_cnt.
//  Output: if_valid_o = head entry allocated && filled; outputs driven from the head entry (registered).
//  - Pop on if_valid_o && if_ready_i.
//  Latency: request accepted in cycle N, response in cycle N+L, if_valid_o high from cycle N+L+1.
//  - Sustains 1 instr/cycle when L < DEPTH and decode is always ready.
//  Simultaneous events:
//  - Alloc and pop in the same cycle when full is legal; occupancy is unchanged.
//  - Response and pop of the same entry cannot coincide (fill is registered first).
//  Redirect (redirect_valid_i=1 in cycle R):
//  - No request in R; all entries invalidated; if_valid_o=0 from R+1.
//  - drop_cnt <= (allocated-unfilled entries) - (1 if a non-dropped response arrives in R).
//  - Back-to-back redirects accumulate onto drop_cnt.
//  - From R+1, pc_i holds the redirect target and requests resume normally.
//  Widths: pointers $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy/drop_cnt $clog2(DEPTH)+1 bits.
//  - drop_cnt never exceeds DEPTH.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//  - Adds outputs perf_fetched_o[31:0] (+1 per pop to decode) and perf_squashed_o[31:0]
//    (+ number of queue entries invalidated per redirect, + each dropped response).
//  - Both counters reset to 0 and wrap at 2^32.
//  FETCH_PERF_EN undefined: neither port nor counter logic exists; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 mid-run with 3 entries queued -> outputs at reset values immediately, occupancy=0.
//  2 Streaming: ready=1, L=1, pc 0,4,8.. -> if_pc_o 0,4,8,12 on consecutive cycles, pc_stall_o=0.
//  3 Backpressure: if_ready_i=0, DEPTH=4 -> exactly 4 requests accepted, then pc_stall_o=1;
//    release -> pops in order 0,4,8,12.
//  4 Memory stall: imem_req_ready_i=0 for 3 cycles -> pc_stall_o=1 and pc_i held;
//    addr stays at the same value until accepted.
//  5 Redirect with 2 in flight: redirect to 32'h100 -> both stale responses dropped, queue empty;
//    first if_pc_o=32'h100 with its matching word.
//  6 FETCH_PERF_EN: scenario 5 -> perf_squashed_o increases by 2 + queued entries;
//    perf_fetched_o equals the number of pops.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order imem requests from the PC and queues returned words for decode.
// Optional FETCH_PERF_EN adds perf_fetched_o / perf_squashed_o event counters.
module fetch_stage #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic        pc_stall_o,
  input  logic        redirect_valid_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  input  logic        if_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_squashed_o
`endif
);

  localparam int unsigned PW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  localparam int unsigned CW = PW + 32'd1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [PW-1:0] PZERO_C = {PW{1'b0}};

  logic [31:0]      pc_q_r    [DEPTH];
  logic [31:0]      instr_q_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
  logic [PW-1:0]    alloc_ptr_r;
  logic [PW-1:0]    fill_ptr_r;
  logic [PW-1:0]    head_ptr_r;
  logic [CW-1:0]    occ_r;
  logic [CW-1:0]    pend_r;
  logic [CW-1:0]    drop_r;

  logic head_valid_s;
  logic pop_s;
  logic req_valid_s;
  logic accept_s;
  logic rsp_take_s;
  logic rsp_drop_s;

  // Handshake decode; a pop frees a slot in the same cycle so a full queue can still accept.
  always_comb begin
    head_valid_s = (occ_r != ZERO_C) && filled_r[head_ptr_r];
    pop_s        = head_valid_s && if_ready_i;
    req_valid_s  = rst_n && !redirect_valid_i && ((occ_r < DEPTH_C) || pop_s);
    accept_s     = req_valid_s && imem_req_ready_i;
    rsp_take_s   = imem_rsp_valid_i && (drop_r == ZERO_C);
    rsp_drop_s   = imem_rsp_valid_i && (drop_r != ZERO_C);
  end

  assign imem_req_valid_o = req_valid_s;
  assign imem_req_addr_o  = pc_i;
  assign pc_stall_o       = !accept_s;
  assign if_valid_o       = head_valid_s;
  assign if_pc_o          = pc_q_r[head_ptr_r];
  assign if_instr_o       = instr_q_r[head_ptr_r];

  // Pointers and counters; a redirect collapses the queue and turns unfilled entries into drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_r <= PZERO_C;
      fill_ptr_r  <= PZERO_C;
      head_ptr_r  <= PZERO_C;
      occ_r       <= ZERO_C;
      pend_r      <= ZERO_C;
      drop_r      <= ZERO_C;
    end else if (redirect_valid_i) begin
      fill_ptr_r <= alloc_ptr_r;
      head_ptr_r <= alloc_ptr_r;
      occ_r      <= ZERO_C;
      pend_r     <= ZERO_C;
      // Any response this cycle either retires a pending entry or consumes a drop.
      drop_r     <= drop_r + pend_r - CW'(imem_rsp_valid_i);
    end else begin
      alloc_ptr_r <= alloc_ptr_r + PW'(accept_s);
      fill_ptr_r  <= fill_ptr_r + PW'(rsp_take_s);
      head_ptr_r  <= head_ptr_r + PW'(pop_s);
      occ_r       <= occ_r + CW'(accept_s) - CW'(pop_s);
      pend_r      <= pend_r + CW'(accept_s) - CW'(rsp_take_s);
      drop_r      <= drop_r - CW'(rsp_drop_s);
    end
  end

  // Entry storage; alloc and fill never target the same slot in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 32'd0; i < DEPTH; i++) begin
        pc_q_r[i]    <= RESET_VECTOR;
        instr_q_r[i] <= 32'h0000_0000;
      end
      filled_r <= {DEPTH{1'b0}};
    end else begin
      if (accept_s) begin
        pc_q_r[alloc_ptr_r]   <= pc_i;
        filled_r[alloc_ptr_r] <= 1'b0;
      end
      if (rsp_take_s && !redirect_valid_i) begin
        instr_q_r[fill_ptr_r] <= imem_rsp_data_i;
        filled_r[fill_ptr_r]  <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_squashed_r;

  // Event counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_r  <= 32'h0000_0000;
      perf_squashed_r <= 32'h0000_0000;
    end else begin
      perf_fetched_r  <= perf_fetched_r + 32'(pop_s);
      perf_squashed_r <= perf_squashed_r
                       + (redirect_valid_i ? 32'(occ_r - CW'(pop_s)) : 32'h0000_0000)
                       + 32'(rsp_drop_s);
    end
  end

  assign perf_fetched_o  = perf_fetched_r;
  assign perf_squashed_o = perf_squashed_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a PC-register model and an in-order fixed-latency memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_stall;
  logic        redirect;
  logic [31:0] target;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        mem_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
  logic [31:0] sq0;
`endif

  int          tests = 0;
  int          fails = 0;
  int          lat   = 1;
  int          cyc   = 0;
  logic [31:0] addr_q [$];
  int          due_q  [$];
  logic [31:0] exp_pc  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] exp_ins [4] = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C};

  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_i             (pc),
    .pc_stall_o       (pc_stall),
    .redirect_valid_i (redirect),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (mem_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .if_valid_o       (if_valid),
    .if_pc_o          (if_pc),
    .if_instr_o       (if_instr),
    .if_ready_i       (if_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o   (perf_fetched),
    .perf_squashed_o  (perf_squashed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // pc register block model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'h0;
    else if (redirect) pc <= target;
    else if (!pc_stall) pc <= pc + 32'd4;
  end

  // in-order memory: request accepted in cycle N answers in cycle N+lat
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q.delete();
      due_q.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
    end else begin
      if (req_valid && mem_ready) begin
        addr_q.push_back(req_addr);
        due_q.push_back(cyc + lat);
      end
      if (addr_q.size() > 0 && due_q[0] <= cyc + 1) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_word(addr_q[0]);
        addr_q.pop_front();
        due_q.pop_front();
      end else begin
        rsp_valid <= 1'b0;
        rsp_data  <= 32'h0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0; if_ready = 1'b0; redirect = 1'b0; lat = 1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; redirect = 1'b0; target = 32'h0; mem_ready = 1'b0; if_ready = 1'b0; lat = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_pc_stall", 32'(pc_stall), 32'h1);
    check("rst_req_valid", 32'(req_valid), 32'h0);

    // streaming, L=1
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; if_ready = 1'b1; #1;
    check("str_stall_c0", 32'(pc_stall), 32'h0);
    check("str_addr_c0", req_addr, 32'h0);
    @(negedge clk); #1;
    check("str_valid_c1", 32'(if_valid), 32'h0);
    check("str_addr_c1", req_addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("str_valid", 32'(if_valid), 32'h1);
      check("str_pc", if_pc, exp_pc[i]);
      check("str_instr", if_instr, exp_ins[i]);
      check("str_stall", 32'(pc_stall), 32'h0);
    end

    // backpressure: exactly DEPTH accepts, then stall; release pops in order
    do_reset();
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; if_ready = 1'b0; #1;
    check("bp_stall_c0", 32'(pc_stall), 32'h0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      check("bp_addr", req_addr, exp_pc[i]);
      check("bp_stall", 32'(pc_stall), 32'h0);
    end
    @(negedge clk); #1;
    check("bp_full_stall", 32'(pc_stall), 32'h1);
    check("bp_full_reqv", 32'(req_valid), 32'h0);
    check("bp_full_head", if_pc, 32'h0);
    @(negedge clk); #1;
    check("bp_full_stall2", 32'(pc_stall), 32'h1);
    check("bp_held_pc", req_addr, 32'h10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if_ready = 1'b1; #1;
      check("bp_pop_pc", if_pc, exp_pc[i]);
      check("bp_pop_instr", if_instr, exp_ins[i]);
      check("bp_pop_stall", 32'(pc_stall), 32'h0);
    end

    // reset mid-run with 3 entries queued
    do_reset();
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; if_ready = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    check("mr_occ3", 32'(dut.occ_r), 32'h3);
    check("mr_head_instr", if_instr, 32'hA5A5_0000);
    @(negedge clk); rst_n = 1'b0; #1;
    check("mr_if_valid", 32'(if_valid), 32'h0);
    check("mr_if_instr", if_instr, 32'h0);
    check("mr_if_pc", if_pc, 32'h0);
    check("mr_stall", 32'(pc_stall), 32'h1);
    check("mr_reqv", 32'(req_valid), 32'h0);
    check("mr_occ0", 32'(dut.occ_r), 32'h0);

    // memory stall for 3 cycles
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; if_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      check("ms_reqv", 32'(req_valid), 32'h1);
      check("ms_stall", 32'(pc_stall), 32'h1);
      check("ms_addr", req_addr, 32'h0);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    check("ms_accept_stall", 32'(pc_stall), 32'h0);
    check("ms_accept_addr", req_addr, 32'h0);
    @(negedge clk); #1;
    check("ms_next_addr", req_addr, 32'h4);
    @(negedge clk); #1;
    check("ms_out_valid", 32'(if_valid), 32'h1);
    check("ms_out_pc", if_pc, 32'h0);
    check("ms_out_instr", if_instr, 32'hA5A5_0000);

    // redirect with 2 requests in flight, L=3
    do_reset();
    @(negedge clk); rst_n = 1'b1; lat = 3; mem_ready = 1'b1; if_ready = 1'b1; #1;
    @(negedge clk); #1;
    check("rd_addr_c1", req_addr, 32'h4);
    @(negedge clk); redirect = 1'b1; target = 32'h100; #1;
    check("rd_reqv_R", 32'(req_valid), 32'h0);
    check("rd_stall_R", 32'(pc_stall), 32'h1);
`ifdef FETCH_PERF_EN
    sq0 = perf_squashed;
`endif
    @(negedge clk); redirect = 1'b0; #1;
    check("rd_addr_tgt", req_addr, 32'h100);
    check("rd_stall_tgt", 32'(pc_stall), 32'h0);
    check("rd_valid_c3", 32'(if_valid), 32'h0);
    for (int i = 4; i < 7; i++) begin
      @(negedge clk); #1;
      check("rd_valid_wait", 32'(if_valid), 32'h0);
`ifdef FETCH_PERF_EN
      if (i == 5) check("perf_squashed", perf_squashed - sq0, 32'd4);
`endif
    end
    @(negedge clk); #1;
    check("rd_out_valid", 32'(if_valid), 32'h1);
    check("rd_out_pc", if_pc, 32'h100);
    check("rd_out_instr", if_instr, 32'hA5A5_0100);
    @(negedge clk); #1;
    check("rd_out_pc2", if_pc, 32'h104);
    check("rd_out_instr2", if_instr, 32'hA5A5_0104);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
